// File: rtl/imem_port_arbiter.sv
// Arbitrates the single instruction-memory port between fetch reads and loader
// writes, with a bounded loader burst and a one-deep fetch response register.
module imem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int MAX_LD_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req_valid,
  input  logic [31:0]       fetch_req_addr,
  output logic              fetch_req_ready,
  input  logic              fetch_flush,
  output logic              fetch_rsp_valid,
  output logic [31:0]       fetch_rsp_instr,
  output logic              fetch_rsp_err,
  input  logic              fetch_rsp_ready,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  output logic              ld_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [3:0]  BURST_MAX = 4'(MAX_LD_BURST);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] instr_reg, instr_next;
  logic        err_reg, err_next;
  logic        bad_reg, bad_next;
  logic        ld_err_reg, ld_err_next;

  logic fetch_bad, ld_bad, grantable, fetch_win, fetch_grant, fetch_read;
  logic ld_grant, ld_write;

  function automatic logic addr_bad(input logic [31:0] a);
    addr_bad = (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
  endfunction

  // Arbitration; every combinational grant is held off while rst_n is low.
  always_comb begin
    fetch_bad   = addr_bad(fetch_req_addr);
    ld_bad      = addr_bad(ld_addr);
    grantable   = rst_n && !fetch_flush &&
                  (state_reg == IDLE || (state_reg == RSP && fetch_rsp_ready));
    fetch_win   = grantable && (!ld_valid || cnt_reg == BURST_MAX);
    fetch_grant = fetch_win && fetch_req_valid;
    fetch_read  = fetch_grant && !fetch_bad;
    // A rejected fetch never touches the port, so the loader may still use it.
    ld_grant    = rst_n && ld_valid && !fetch_read;
    ld_write    = ld_grant && !ld_bad;
  end

  assign fetch_req_ready = fetch_win;
  assign ld_ready        = ld_grant;
  assign mem_en          = fetch_read || ld_write;
  assign mem_we          = ld_write;
  assign mem_addr        = fetch_read ? fetch_req_addr[ADDR_W+1:2] :
                           ld_write   ? ld_addr[ADDR_W+1:2] : '0;
  assign mem_wdata       = ld_write ? ld_data : '0;
  assign fetch_rsp_valid = (state_reg == RSP);
  assign fetch_rsp_instr = instr_reg;
  assign fetch_rsp_err   = err_reg;
  assign ld_err          = ld_err_reg;

  always_comb begin
    state_next  = state_reg;
    instr_next  = instr_reg;
    err_next    = err_reg;
    bad_next    = bad_reg;
    cnt_next    = cnt_reg;
    ld_err_next = ld_grant && ld_bad;

    case (state_reg)
      IDLE: begin
        if (fetch_grant) begin
          state_next = RD_WAIT;
          bad_next   = fetch_bad;
        end
      end
      RD_WAIT: begin
        state_next = RSP;
        instr_next = bad_reg ? NOP_INSTR : mem_rdata;
        err_next   = bad_reg;
      end
      RSP: begin
        if (fetch_rsp_ready) begin
          state_next = fetch_grant ? RD_WAIT : IDLE;
          if (fetch_grant) bad_next = fetch_bad;
        end
      end
      default: state_next = IDLE;
    endcase

    if (fetch_flush) state_next = IDLE;

    // Counts loader wins against a fetch that could otherwise have gone.
    if (!fetch_req_valid || fetch_grant)
      cnt_next = '0;
    else if (ld_grant && grantable && cnt_reg < BURST_MAX)
      cnt_next = cnt_reg + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      instr_reg  <= '0;
      err_reg    <= 1'b0;
      bad_reg    <= 1'b0;
      ld_err_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      instr_reg  <= instr_next;
      err_reg    <= err_next;
      bad_reg    <= bad_next;
      ld_err_reg <= ld_err_next;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: memory macro model, per-cycle reference model,
// table-driven write/fetch vectors, directed corner sequences and random traffic.
module tb_imem_port_arbiter;
  localparam int AW = 8;
  localparam int MB = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  logic fetch_req_valid, fetch_req_ready, fetch_flush;
  logic [31:0] fetch_req_addr;
  logic fetch_rsp_valid, fetch_rsp_err, fetch_rsp_ready;
  logic [31:0] fetch_rsp_instr;
  logic ld_valid, ld_ready, ld_err;
  logic [31:0] ld_addr, ld_data;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(AW), .MAX_LD_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr),
    .fetch_req_ready(fetch_req_ready), .fetch_flush(fetch_flush),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_instr(fetch_rsp_instr),
    .fetch_rsp_err(fetch_rsp_err), .fetch_rsp_ready(fetch_rsp_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_err(ld_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory macro: synchronous single port, registered read data.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: age of the outstanding fetch (-1 none, 1 read issued, 2 response held).
  logic [31:0] refmem [0:(1<<AW)-1];
  int          m_age = -1;
  int          m_cnt = 0;
  logic [31:0] m_inst = '0;
  logic        m_err = 1'b0;
  logic        m_lderr = 1'b0;

  logic s_freq_ready, s_ld_ready, s_rsp_valid, s_rsp_err, s_ld_err, s_mem_en, s_mem_we;
  logic [31:0] s_instr;

  function automatic bit is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 0);
  endfunction

  task automatic cycle();
    bit free, grantable, fg, lg, fbad, lbad, e_en, e_we;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    cyc++;
    s_freq_ready = fetch_req_ready; s_ld_ready = ld_ready; s_rsp_valid = fetch_rsp_valid;
    s_instr = fetch_rsp_instr; s_rsp_err = fetch_rsp_err; s_ld_err = ld_err;
    s_mem_en = mem_en; s_mem_we = mem_we;
    if (!rst_n) begin
      chk("reset_outs", {fetch_req_ready, ld_ready, mem_en, mem_we, fetch_rsp_valid,
                         fetch_rsp_err, ld_err, mem_addr}, 32'd0);
      chk("reset_instr", fetch_rsp_instr, 32'd0);
      chk("reset_wdata", mem_wdata, 32'd0);
      m_age = -1; m_cnt = 0; m_lderr = 1'b0;
      @(posedge clk); #1;
      return;
    end
    free      = (m_age < 0) || (m_age == 2 && fetch_rsp_ready);
    grantable = !fetch_flush && free;
    fbad      = is_bad(fetch_req_addr);
    lbad      = is_bad(ld_addr);
    fg        = fetch_req_valid && grantable && (!ld_valid || m_cnt == MB);
    lg        = ld_valid && !(fg && !fbad);
    e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    if (fg && !fbad) begin
      e_en = 1; e_addr = fetch_req_addr >> 2;
    end else if (lg && !lbad) begin
      e_en = 1; e_we = 1; e_addr = ld_addr >> 2; e_wdata = ld_data;
    end
    if (fetch_req_valid) chk("fetch_req_ready", fetch_req_ready, fg);
    chk("ld_ready", ld_ready, lg);
    chk("rsp_valid", fetch_rsp_valid, m_age == 2);
    if (m_age == 2) begin
      chk("rsp_instr", fetch_rsp_instr, m_inst);
      chk("rsp_err", fetch_rsp_err, m_err);
    end
    chk("ld_err", ld_err, m_lderr);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    if (lg) $display("LD    addr=%h data=%h %s", ld_addr, ld_data, lbad ? "dropped" : "written");
    if (fg) $display("FETCH addr=%h accepted", fetch_req_addr);
    if (m_age == 2 && fetch_rsp_ready && !fetch_flush)
      $display("RSP   instr=%h err=%0b", fetch_rsp_instr, fetch_rsp_err);
    @(posedge clk); #1;
    if (fetch_flush) m_age = -1;
    else if (fg) begin
      m_age = 1; m_err = fbad;
      m_inst = fbad ? NOP : refmem[fetch_req_addr[AW+1:2]];
    end else if (m_age == 2 && fetch_rsp_ready) m_age = -1;
    else if (m_age == 1) m_age = 2;
    if (!fetch_req_valid || fg) m_cnt = 0;
    else if (lg && grantable && m_cnt < MB) m_cnt++;
    m_lderr = lg && lbad;
    if (lg && !lbad) refmem[ld_addr[AW+1:2]] = ld_data;
  endtask

  task automatic idle_inputs();
    fetch_req_valid = 0; fetch_req_addr = 0; fetch_flush = 0; fetch_rsp_ready = 1;
    ld_valid = 0; ld_addr = 0; ld_data = 0;
  endtask

  typedef struct {
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [31:0] f_addr;
    logic [31:0] exp_instr;
    logic        exp_err;
    logic        exp_lderr;
  } vec_t;
  vec_t tbl [6];

  int acc [$];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i] = v;
      refmem[i] = v;
    end
    tbl[0] = '{32'h0000_0000, 32'h0053_02b3, 32'h0000_0000, 32'h0053_02b3, 1'b0, 1'b0};
    tbl[1] = '{32'h0000_03fc, 32'hdead_beef, 32'h0000_03fc, 32'hdead_beef, 1'b0, 1'b0};
    tbl[2] = '{32'h0000_03ff, 32'h0000_0001, 32'h0000_0002, NOP,           1'b1, 1'b1};
    tbl[3] = '{32'h0000_0400, 32'h0000_0002, 32'h0000_0400, NOP,           1'b1, 1'b1};
    tbl[4] = '{32'h0000_0010, 32'ha5a5_a5a5, 32'h0000_0010, 32'ha5a5_a5a5, 1'b0, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h0000_0003, 32'h0000_03fc, 32'hdead_beef, 1'b0, 1'b1};

    idle_inputs();
    rst_n = 0;
    repeat (2) cycle();
    rst_n = 1;
    cycle();

    // Table: loader write in cycle N, fetch accepted N+1, response at N+3.
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1; ld_addr = tbl[i].ld_addr; ld_data = tbl[i].ld_data;
      cycle();
      chk($sformatf("v%0d_ld_ready", i), s_ld_ready, 1'b1);
      chk($sformatf("v%0d_mem_we", i), s_mem_we, !tbl[i].exp_lderr);
      ld_valid = 0; fetch_req_valid = 1; fetch_req_addr = tbl[i].f_addr;
      cycle();
      chk($sformatf("v%0d_ld_err", i), s_ld_err, tbl[i].exp_lderr);
      chk($sformatf("v%0d_accept", i), s_freq_ready, 1'b1);
      chk($sformatf("v%0d_fetch_mem_en", i), s_mem_en, !tbl[i].exp_err);
      fetch_req_valid = 0;
      cycle();
      chk($sformatf("v%0d_rsp_early", i), s_rsp_valid, 1'b0);
      cycle();
      chk($sformatf("v%0d_rsp_valid", i), s_rsp_valid, 1'b1);
      chk($sformatf("v%0d_instr", i), s_instr, tbl[i].exp_instr);
      chk($sformatf("v%0d_err", i), s_rsp_err, tbl[i].exp_err);
      cycle();
    end

    // Continuous contention: 4 contended loader wins, then the fetch.
    fetch_req_valid = 1; fetch_req_addr = 32'h0000_0010;
    ld_valid = 1; ld_addr = 32'h0000_0020;
    for (int i = 0; i < 20; i++) begin
      ld_data = $urandom;
      cycle();
      if (s_freq_ready) acc.push_back(cyc);
    end
    idle_inputs();
    chk("burst_first_accept", acc.size() > 0 ? acc[0] - (cyc - 19) : -1, 32'd4);
    for (int i = 1; i < acc.size(); i++)
      chk($sformatf("burst_spacing%0d", i), acc[i] - acc[i-1], 32'd6);
    chk("burst_accepts", acc.size(), 32'd3);
    repeat (3) cycle();

    // Back-pressure: response held stable, fetch blocked, loader still writing.
    fetch_req_valid = 1; fetch_req_addr = 32'h0; fetch_rsp_ready = 0;
    cycle();
    fetch_req_valid = 0;
    repeat (2) cycle();
    fetch_req_valid = 1; fetch_req_addr = 32'h4;
    ld_valid = 1; ld_addr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      ld_data = $urandom;
      cycle();
      chk("hold_valid", s_rsp_valid, 1'b1);
      chk("hold_instr", s_instr, 32'h0053_02b3);
      chk("hold_freq_ready", s_freq_ready, 1'b0);
      chk("hold_ld_ready", s_ld_ready, 1'b1);
    end
    ld_valid = 0; fetch_rsp_ready = 1;
    cycle();
    chk("b2b_accept", s_freq_ready, 1'b1);
    fetch_req_valid = 0;
    repeat (3) cycle();

    // Flush while the read is in flight, then while a response is held.
    fetch_req_valid = 1; fetch_req_addr = 32'h10;
    cycle();
    fetch_req_valid = 0; fetch_flush = 1;
    cycle();
    fetch_flush = 0;
    cycle();
    chk("flush_rdwait_rsp", s_rsp_valid, 1'b0);
    cycle();
    chk("flush_rdwait_rsp2", s_rsp_valid, 1'b0);
    fetch_req_valid = 1; fetch_rsp_ready = 0;
    cycle();
    fetch_req_valid = 0;
    repeat (2) cycle();
    fetch_req_valid = 1; fetch_flush = 1;
    cycle();
    chk("flush_blocks_accept", s_freq_ready, 1'b0);
    fetch_flush = 0; fetch_req_valid = 0; fetch_rsp_ready = 1;
    cycle();
    chk("flush_rsp_dropped", s_rsp_valid, 1'b0);
    fetch_req_valid = 1;
    cycle();
    fetch_req_valid = 0;
    repeat (2) cycle();
    chk("post_flush_instr", s_instr, refmem[4]);

    // Asynchronous reset in the middle of a read.
    fetch_req_valid = 1; fetch_req_addr = 32'h0;
    cycle();
    ld_valid = 1; ld_addr = 32'h8;
    rst_n = 0;
    #1;
    chk("async_reset_outs", {fetch_req_ready, ld_ready, mem_en, fetch_rsp_valid, ld_err}, 32'd0);
    repeat (2) cycle();
    idle_inputs();
    rst_n = 1;
    repeat (4) begin
      cycle();
      chk("no_rsp_after_reset", s_rsp_valid, 1'b0);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      fetch_req_valid = ($urandom_range(99) < 60);
      fetch_req_addr  = ($urandom_range(9) == 0) ? $urandom : {$urandom_range(15), 2'b00};
      ld_valid        = ($urandom_range(99) < 50);
      ld_addr         = ($urandom_range(9) == 0) ? $urandom : {$urandom_range(15), 2'b00};
      ld_data         = $urandom;
      fetch_rsp_ready = ($urandom_range(99) < 70);
      fetch_flush     = ($urandom_range(99) < 5);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
